imm_encoder: RTL

Pipelined RV64 instruction encoder, the inverse of the immediate generator. It accepts decoded fields (opcode, funct3, register indices and a signed 64-bit immediate) and packs them into a 32-bit I-, S- or B-type instruction word. It range-checks the immediate against the target format and reports violations. It sits in the test/assembly path that feeds instruction memory, and uses valid/ready handshakes on both sides.

---
 rtl/imm_encoder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: packs opcode/funct3/register/immediate fields into 32-bit
// RV64 I-, S- or B-type instruction words. It flags immediates that do not
// fit the target format, and flags unsupported opcodes.
// The design is a two-stage valid/ready pipeline with a saturating error counter.
module imm_encoder #(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [4:0]          rd,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic signed [63:0]  imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         instr,
    output logic                out_err,
    output logic [CNT_W-1:0]    err_count
);

    typedef enum logic [1:0] {
        FMT_I   = 2'd0,
        FMT_S   = 2'd1,
        FMT_B   = 2'd2,
        FMT_BAD = 2'd3
    } fmt_e;

    // Map an opcode to the instruction format it is encoded with.
    function automatic fmt_e fmt_of(input logic [6:0] op);
        fmt_e f;
        case (op)
            7'b0000011,
            7'b0010011: f = FMT_I;
            7'b0100011: f = FMT_S;
            7'b1100011: f = FMT_B;
            default:    f = FMT_BAD;
        endcase
        return f;
    endfunction

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic        s1_v;
    logic        s2_v;
    logic        in_fire;
    logic        s2_load;
    logic        out_fire;
    logic        fits12;
    logic        fits13;
    logic [31:0] enc_word_p0;
    logic        enc_err_p0;
    logic [31:0] word_p1;
    logic        err_p1;

    // Handshake: S1 can take a request whenever it is empty or is draining.
    assign in_ready  = !s1_v || !s2_v || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign s2_load   = s1_v && (!s2_v || out_ready);
    assign out_fire  = s2_v && out_ready;
    assign out_valid = s2_v;

    // Range checks: a value fits in N signed bits when every bit above N-1 matches the sign.
    assign fits12 = (imm[63:11] == '0) || (imm[63:11] == '1);
    assign fits13 = (imm[63:12] == '0) || (imm[63:12] == '1);

    // Format selection, legality and field packing for the incoming request.
    always_comb begin
        enc_word_p0 = '0;
        enc_err_p0  = 1'b0;
        case (fmt_of(opcode))
            FMT_I: begin
                if (fits12) enc_word_p0 = {imm[11:0], rs1, funct3, rd, opcode};
                else        enc_err_p0  = 1'b1;
            end
            FMT_S: begin
                if (fits12) enc_word_p0 = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                else        enc_err_p0  = 1'b1;
            end
            FMT_B: begin
                if (fits13 && !imm[0])
                    enc_word_p0 = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                else
                    enc_err_p0  = 1'b1;
            end
            default: enc_err_p0 = 1'b1;
        endcase
    end

    // ---- S1: capture request result ----
    // S1 occupancy: filled on acceptance, emptied when its word moves to S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       s1_v <= 1'b0;
        else if (in_fire) s1_v <= 1'b1;
        else if (s2_load) s1_v <= 1'b0;
    end

    // S1 payload; only meaningful while s1_v is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            word_p1 <= enc_word_p0;
            err_p1  <= enc_err_p0;
        end
    end

    // ---- S2: output holding register ----
    // S2 loads from S1 when free or draining, and otherwise holds its word stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v    <= 1'b0;
            instr   <= '0;
            out_err <= 1'b0;
        end else if (s2_load) begin
            s2_v    <= 1'b1;
            instr   <= word_p1;
            out_err <= err_p1;
        end else if (out_fire) begin
            s2_v    <= 1'b0;
        end
    end

    // Error counter advances only when an errored word is handed to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   err_count <= '0;
        else if (out_fire && out_err) err_count <= sat_inc(err_count);
    end

endmodule
